dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have port: clock  in  1  master clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset; asserted (0) clears state immediately, independent of clock.
REQ-003 SHALL have port: address_dmem  in  32  word address from processor memory stage.
REQ-004 SHALL have port: data  in  32  store data from processor.
REQ-005 SHALL have port: wren  in  1  store strobe; 1 = write this cycle.
REQ-006 SHALL have port: q_dmem  out  32  registered read data to processor.
REQ-007 SHALL have port: out_data  out  32  TX FIFO head word.
REQ-008 SHALL have port: out_valid  out  1  TX FIFO non-empty.
REQ-009 SHALL have port: out_ready  in  1  downstream sink accepts head word.
REQ-010 SHALL have parameter: RAM_WORDS, default 4096, RAM depth in words (power of two, at most 4096).
REQ-011 SHALL have parameter: FIFO_DEPTH, default 8, TX FIFO depth (power of two).

Function
REQ-012 SHALL decode word addresses as follows:
- 0x0000_0000..RAM_WORDS-1: RAM.
- 0x0000_1000: TX (write = push, read = status).
- 0x0000_1001: CYCLE counter.
- All other addresses: unmapped.
REQ-013 SHALL register q_dmem on every rising edge from the address presented before that edge (1-cycle read latency), whatever the value of wren.
REQ-014 SHALL provide read-before-write: a read and a write to the same address in one cycle return the old value.
REQ-015 SHALL write data to RAM[address] on a rising edge when wren=1 and the address is in RAM range.
REQ-016 SHALL return status on a read of TX: {29'b0, ovf, full, empty}, sampled before the edge.
REQ-017 SHALL return 0 on a read of an unmapped address and SHALL ignore writes to unmapped addresses.
REQ-018 SHALL push data into the TX FIFO when wren=1, address=TX and the FIFO is not full before the edge.
REQ-019 SHALL drop the word and set sticky ovf when a TX push is attempted while full, even if a pop occurs in the same cycle.
REQ-020 SHALL clear ovf on a rising edge with wren=0 and address=TX (read-clear), unless a dropped push sets it in the same cycle, in which case set wins.
REQ-021 SHALL drive out_valid=(count!=0) and out_data=the head entry, both as registered or state-derived signals, never depending combinationally on out_ready.
REQ-022 SHALL pop the head on a rising edge when out_valid=1 and out_ready=1.
REQ-023 SHALL, on a simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL hold count in the range 0..FIFO_DEPTH, with pointers wrapping modulo FIFO_DEPTH.
REQ-025 SHALL hold the head word stable while out_valid=1 and out_ready=0.
REQ-026 SHALL increment the 32-bit CYCLE counter every rising edge, wrapping 0xFFFF_FFFF to 0.
REQ-027 SHALL load CYCLE from data when wren=1 and address=CYCLE; the load takes priority over the increment for that edge.
REQ-028 SHALL return the pre-edge CYCLE value on a read of CYCLE.

Reset
REQ-029 SHALL, while reset=0, force q_dmem=0, out_valid=0, count=0, pointers=0, ovf=0 and CYCLE=0.
REQ-030 SHALL NOT clear RAM contents on reset; RAM contents are undefined until written.
REQ-031 SHALL discard all queued FIFO entries on reset asserted mid-operation, with no pop or handshake on out_*.
REQ-032 SHALL ignore wren and out_ready while reset=0.
REQ-033 SHALL resume operation on the first rising edge after reset returns to 1.

Verification
REQ-034 Bench SHALL cover: write 0xDEADBEEF to address 5, read address 5 next cycle -> q_dmem=0xDEADBEEF one edge after the address is presented; same-cycle read and write of address 5 with 0x1 -> returns old value 0xDEADBEEF.
REQ-035 Bench SHALL cover: out_ready=0, push 9 words 1..9 to TX -> status reads 0b110 (ovf=1, full=1, empty=0); next status read -> 0b010; then draining with out_ready=1 yields 1..8 in order and out_valid=0.
REQ-036 Bench SHALL cover: FIFO full with out_ready=1 and a push of 0xA in the same cycle -> word dropped, ovf=1, count=7.
REQ-037 Bench SHALL cover: FIFO with 3 entries, push and pop every cycle for 20 cycles -> count stays 3, output order preserved across pointer wrap.
REQ-038 Bench SHALL cover: write 0xFFFF_FFFE to CYCLE, read CYCLE two cycles later -> 0x0000_0000 (wrap); read of address 0x2000 -> 0.
REQ-039 Bench SHALL cover: 4 entries queued, ovf=1, reset pulsed low between edges -> out_valid=0, status=0b001 and CYCLE=0 immediately, before the next edge.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, a TX FIFO at 0x1000 and a free-running
// cycle counter at 0x1001, with 1-cycle registered read data.
module dmem_responder #(
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] TX_ADDR  = 32'h0000_1000;
    localparam logic [31:0] CYC_ADDR = 32'h0000_1001;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [31:0]   ram  [RAM_WORDS];
    logic [31:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycle_cnt;

    logic in_ram, is_tx, is_cyc, full, empty, push_req, push, drop, pop;
    logic [31:0] rd_val;

    assign in_ram   = address_dmem < 32'(RAM_WORDS);
    assign is_tx    = address_dmem == TX_ADDR;
    assign is_cyc   = address_dmem == CYC_ADDR;
    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign push_req = wren && is_tx;
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign pop      = out_valid && out_ready;

    // Head output comes straight from state so it never depends on out_ready.
    assign out_valid = !empty;
    assign out_data  = fifo[rd_ptr];

    always_comb begin
        rd_val = '0;
        if (in_ram)      rd_val = ram[address_dmem[AW-1:0]];
        else if (is_tx)  rd_val = {29'b0, ovf, full, empty};
        else if (is_cyc) rd_val = cycle_cnt;
    end

    // Storage arrays are never reset; writes are blocked while reset is held.
    always_ff @(posedge clock) begin
        if (reset && wren && in_ram) ram[address_dmem[AW-1:0]] <= data;
    end

    always_ff @(posedge clock) begin
        if (reset && push) fifo[wr_ptr] <= data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            q_dmem <= rd_val;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            // A dropped push outranks the read-clear of the status word.
            if (drop)                ovf <= 1'b1;
            else if (!wren && is_tx) ovf <= 1'b0;
            if (wren && is_cyc) cycle_cnt <= data;
            else                cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + random bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;
    localparam int RW = 4096;
    localparam int FD = 8;
    localparam logic [31:0] TX  = 32'h1000;
    localparam logic [31:0] CYC = 32'h1001;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem, data, q_dmem, out_data;
    logic        wren, out_valid, out_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mram [int];
    logic [31:0] mq [$];
    bit          movf;
    logic [31:0] mcyc;
    logic [31:0] last_q;

    dmem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        movf = 1'b0;
        mcyc = '0;
    endtask

    // One clock: drive at the falling edge, predict, check just after the rising edge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        logic [31:0] eq;
        bit known, was_full;
        address_dmem = a; data = d; wren = w; out_ready = r;
        known = 1'b1;
        eq = '0;
        if (a < RW) begin
            if (mram.exists(int'(a))) eq = mram[int'(a)];
            else known = 1'b0;
        end else if (a == TX) begin
            eq = {29'b0, movf, mq.size() == FD, mq.size() == 0};
        end else if (a == CYC) begin
            eq = mcyc;
        end
        was_full = (mq.size() == FD);
        if (r && mq.size() != 0) void'(mq.pop_front());
        if (w && a == TX) begin
            if (was_full) movf = 1'b1;
            else mq.push_back(d);
        end else if (!w && a == TX) begin
            movf = 1'b0;
        end
        if (w && a < RW) mram[int'(a)] = d;
        mcyc = (w && a == CYC) ? d : mcyc + 32'd1;
        @(posedge clock); #1;
        if (known) check("q_dmem", q_dmem, eq);
        check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) check("out_data", out_data, mq[0]);
        check("count", 32'(dut.count), 32'(mq.size()));
        last_q = q_dmem;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b0; address_dmem = '0; data = '0; wren = 1'b0; out_ready = 1'b0;
        model_reset();
        // Held reset: writes and handshakes must be ignored.
        repeat (2) @(posedge clock);
        wren = 1'b1; address_dmem = TX; data = 32'h55; out_ready = 1'b1;
        @(posedge clock); #1;
        check("rst_q", q_dmem, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_count", 32'(dut.count), 32'h0);
        check("rst_cycle", dut.cycle_cnt, 32'h0);
        @(negedge clock);
        wren = 1'b0; out_ready = 1'b0; reset = 1'b1;

        // RAM write, read-back, read-before-write.
        cyc(32'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        cyc(32'd5, 32'h0, 1'b0, 1'b0);
        check("ram_rd", last_q, 32'hDEADBEEF);
        cyc(32'd5, 32'h1, 1'b1, 1'b0);
        check("ram_rbw", last_q, 32'hDEADBEEF);
        cyc(32'd5, 32'h0, 1'b0, 1'b0);
        check("ram_new", last_q, 32'h1);

        // Overflow: 9 pushes into 8 entries, sticky/read-clear ovf, ordered drain.
        for (int i = 1; i <= 9; i++) cyc(TX, 32'(i), 1'b1, 1'b0);
        cyc(TX, 32'h0, 1'b0, 1'b0);
        check("stat_ovf", last_q, 32'h6);
        cyc(TX, 32'h0, 1'b0, 1'b0);
        check("stat_clr", last_q, 32'h2);
        for (int i = 1; i <= 8; i++) begin
            check("drain_head", out_data, 32'(i));
            cyc(32'h2000, 32'h0, 1'b0, 1'b1);
        end
        check("drain_empty", {31'b0, out_valid}, 32'h0);

        // Push while full with a simultaneous pop: word dropped, count 7.
        for (int i = 0; i < 8; i++) cyc(TX, 32'h100 + 32'(i), 1'b1, 1'b0);
        cyc(TX, 32'hA, 1'b1, 1'b1);
        check("drop_cnt", 32'(dut.count), 32'd7);
        cyc(TX, 32'h0, 1'b0, 1'b0);
        check("drop_stat", last_q, 32'h4);
        for (int i = 0; i < 7; i++) cyc(32'h2000, 32'h0, 1'b0, 1'b1);

        // Steady push+pop at depth 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cyc(TX, 32'h200 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("ss_head", out_data, 32'h200 + 32'(i));
            cyc(TX, 32'h203 + 32'(i), 1'b1, 1'b1);
        end
        check("ss_cnt", 32'(dut.count), 32'd3);
        for (int i = 0; i < 3; i++) cyc(32'h2000, 32'h0, 1'b0, 1'b1);

        // Cycle counter load and wrap; unmapped read.
        cyc(CYC, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cyc(32'h2000, 32'h0, 1'b0, 1'b0);
        cyc(32'h2000, 32'h0, 1'b0, 1'b0);
        check("unmapped", last_q, 32'h0);
        cyc(CYC, 32'h0, 1'b0, 1'b0);
        check("cyc_wrap", last_q, 32'h0);
        cyc(32'h2000, 32'h1234, 1'b1, 1'b0);
        cyc(32'h2000, 32'h0, 1'b0, 1'b0);
        check("unmapped_wr", last_q, 32'h0);

        // Mid-operation reset with 4 queued and ovf set.
        for (int i = 0; i < 9; i++) cyc(TX, 32'h300 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(32'h2000, 32'h0, 1'b0, 1'b1);
        check("pre_rst_cnt", 32'(dut.count), 32'd4);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_q", q_dmem, 32'h0);
        check("mid_rst_ovf", {31'b0, dut.ovf}, 32'h0);
        check("mid_rst_cycle", dut.cycle_cnt, 32'h0);
        wren = 1'b1; address_dmem = TX; data = 32'h77; out_ready = 1'b1;
        @(posedge clock); #1;
        check("rst_ign_cnt", 32'(dut.count), 32'h0);
        @(negedge clock);
        wren = 1'b0; out_ready = 1'b0; reset = 1'b1;
        model_reset();
        cyc(TX, 32'h0, 1'b0, 1'b0);
        check("post_rst_stat", last_q, 32'h1);
        cyc(CYC, 32'h0, 1'b0, 1'b0);
        check("post_rst_cyc", last_q, 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = 32'($urandom_range(0, 15));
                2:       a = TX;
                3:       a = CYC;
                4:       a = 32'h2000 + 32'($urandom_range(0, 255));
                default: a = $urandom;
            endcase
            cyc(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
